// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and opcode latency lookup for the ALU sequencer.
package alu_seq_pkg;

    localparam int unsigned OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_ADC  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_SBB  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_FADD = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_FSUB = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_FMUL = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_NAND = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_XNOR = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // EXEC cycle count for an opcode; 0 marks float/unassigned opcodes as illegal.
    function automatic int unsigned op_latency(
        input logic [OPCODE_W-1:0] opcode,
        input int unsigned         lat_add   = 2,
        input int unsigned         lat_mul   = 4,
        input int unsigned         lat_logic = 1
    );
        int unsigned lat;
        lat = 0;
        if (opcode <= OP_SBB) begin
            lat = lat_add;
        end else if (opcode == OP_MUL) begin
            lat = lat_mul;
        end else if (opcode >= OP_AND && opcode <= OP_NEG) begin
            lat = lat_logic;
        end
        return lat;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone valid always wins, the pointer breaks ties.
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic pointer,
    output logic grant0,
    output logic grant1
);

    // pointer=0 favours requester 0, pointer=1 favours requester 1
    always_comb begin
        grant0 = valid0 && (!valid1 || !pointer);
        grant1 = valid1 && (!valid0 || pointer);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one operation at a time from two round-robin requesters to a fixed-latency ALU
// and returns the captured result tagged with the winning requester's index.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LAT_ADD   = 2,
    parameter int unsigned LAT_MUL   = 4,
    parameter int unsigned LAT_LOGIC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [4:0]          req0_opcode,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [4:0]          req1_opcode,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_err,
    output logic [4:0]          alu_opcode,
    output logic                alu_enable,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    input  logic [WIDTH-1:0]    alu_out
);

    localparam int unsigned CNT_W = 8;

    state_t             state;
    logic               ptr;
    logic [CNT_W-1:0]   cnt;
    logic               grant0;
    logic               grant1;
    logic               hs;
    logic               sel_id;
    logic [4:0]         sel_opcode;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    int unsigned        sel_lat;

    rr_arbiter_2 u_arb (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .pointer (ptr),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Accept only while idle; ready is forced low for the whole reset assertion
    always_comb begin
        req0_ready = rst_n && (state == ST_IDLE) && grant0;
        req1_ready = rst_n && (state == ST_IDLE) && grant1;
        hs         = req0_ready || req1_ready;
        sel_id     = req1_ready;
        sel_opcode = sel_id ? req1_opcode : req0_opcode;
        sel_a      = sel_id ? req1_a : req0_a;
        sel_b      = sel_id ? req1_b : req0_b;
        sel_lat    = op_latency(sel_opcode, LAT_ADD, LAT_MUL, LAT_LOGIC);
    end

    // Sequencer FSM; the ALU drive registers double as the operand latches during EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            alu_opcode <= '0;
            alu_enable <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        rsp_id <= sel_id;
                        if (sel_lat == 0) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            cnt        <= CNT_W'(sel_lat - 1);
                            alu_enable <= 1'b1;
                            alu_opcode <= sel_opcode;
                            alu_a      <= sel_a;
                            alu_b      <= sel_b;
                            state      <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        rsp_data   <= alu_out;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        alu_enable <= 1'b0;
                        alu_opcode <= '0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-timeline reference model plus directed scenarios.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  alu_opcode;
    logic        alu_enable;
    logic [31:0] alu_a, alu_b, alu_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int en_cnt = 0;
    bit rand_done = 0;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .alu_opcode  (alu_opcode),
        .alu_enable  (alu_enable),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU semantics (also the source of expected results)
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a + b + 32'd1;
            5'd2:    return a - b;
            5'd3:    return a - b - 32'd1;
            5'd4:    return a * b;
            5'd8:    return a & b;
            5'd9:    return a | b;
            5'd10:   return a ^ b;
            5'd11:   return ~(a & b);
            5'd12:   return ~(a | b);
            5'd13:   return ~(a ^ b);
            5'd14:   return ~a;
            5'd15:   return 32'd0 - a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op);
        if (op < 5'd4) return 2;
        if (op == 5'd4) return 4;
        if (op >= 5'd8 && op <= 5'd15) return 1;
        return 0;
    endfunction

    // Stand-in ALU: garbage when not enabled so a mistimed capture is visible
    assign alu_out = alu_enable ? ref_alu(alu_opcode, alu_a, alu_b) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction described by its handshake cycle and latency
    bit          m_busy = 0;
    bit          m_ptr  = 0;
    int          m_t    = 0;
    int          m_lat  = 0;
    logic        m_id   = 1'b0;
    logic [4:0]  m_op   = 5'd0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic        m_err  = 1'b0;

    always @(negedge clk) begin
        bit ex, rv, e0, e1;
        if (alu_enable) en_cnt++;
        if (!rst_n) begin
            chk("rst_req0_ready", 32'(req0_ready), 32'd0);
            chk("rst_req1_ready", 32'(req1_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
            chk("rst_alu_enable", 32'(alu_enable), 32'd0);
            chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
            chk("rst_alu_a", alu_a, 32'd0);
            chk("rst_alu_b", alu_b, 32'd0);
            m_busy = 0;
            m_ptr  = 0;
        end else begin
            ex = m_busy && (cyc > m_t) && (cyc <= m_t + m_lat);
            rv = m_busy && (cyc >= m_t + m_lat + 1);
            e0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
            e1 = !m_busy && req1_valid && (!req0_valid || m_ptr);
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("alu_enable", 32'(alu_enable), 32'(ex));
            chk("alu_opcode", 32'(alu_opcode), ex ? 32'(m_op) : 32'd0);
            chk("alu_a", alu_a, ex ? m_a : 32'd0);
            chk("alu_b", alu_b, ex ? m_b : 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(rv));
            if (rv) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (e0 || e1) begin
                m_busy = 1;
                m_t    = cyc;
                m_id   = e1;
                m_op   = e1 ? req1_opcode : req0_opcode;
                m_a    = e1 ? req1_a : req0_a;
                m_b    = e1 ? req1_b : req0_b;
                m_lat  = ref_lat(m_op);
                m_err  = (m_lat == 0);
                m_data = (m_lat == 0) ? 32'd0 : ref_alu(m_op, m_a, m_b);
            end else if (rv && rsp_ready) begin
                m_busy = 0;
                m_ptr  = ~m_id;
            end
        end
    end

    // Drive a request (caller is just after a rising edge) and hold it until accepted
    task automatic issue(input int port, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int t);
        int n;
        bit got;
        n   = 0;
        got = 0;
        if (port == 0) begin
            req0_opcode = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_opcode = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        while (!got && n < 3000) begin
            @(negedge clk);
            got = (port == 0) ? req0_ready : req1_ready;
            n++;
        end
        t = cyc;
        if (!got) chk("handshake_timeout", 32'((port == 0) ? req0_ready : req1_ready), 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    // Returns the cycle in which rsp_valid is first seen (sampled at the falling edge)
    task automatic wait_rsp(output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        t = cyc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_port(input int port, input int nops);
        logic [4:0] op;
        int unsigned r;
        int t;
        for (int i = 0; i < nops; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      op = 5'($urandom_range(0, 31));
            else if (r < 5) op = 5'($urandom_range(0, 4));
            else            op = 5'($urandom_range(8, 15));
            issue(port, op, $urandom, $urandom, t);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int t0, t1, t2;
        rst_n       = 1'b0;
        rsp_ready   = 1'b0;
        req0_valid  = 1'b0; req0_opcode = 5'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid  = 1'b0; req1_opcode = 5'd0; req1_a = 32'd0; req1_b = 32'd0;

        // Reset holds ready low even with a valid request present
        #2;
        req0_valid  = 1'b1;
        req0_opcode = 5'd8;
        #10;
        chk("reset_ready_gated", 32'(req0_ready), 32'd0);
        chk("reset_alu_enable", 32'(alu_enable), 32'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_ready0", 32'(req0_ready), 32'd0);
            chk("idle_enable", 32'(alu_enable), 32'd0);
        end
        @(posedge clk);
        #1;

        // AND, single logic cycle
        rsp_ready = 1'b1;
        en_cnt    = 0;
        issue(0, 5'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, t0);
        wait_rsp(t1);
        chk("and_latency", 32'(t1 - t0), 32'd2);
        chk("and_data", rsp_data, 32'hF000_F000);
        chk("and_id", 32'(rsp_id), 32'd0);
        chk("and_err", 32'(rsp_err), 32'd0);
        chk("and_enable_cycles", 32'(en_cnt), 32'd1);
        @(posedge clk);
        #1;

        // Contention: req0 first, then req1, then a re-raised req0
        do_reset();
        fork
            begin
                issue(0, 5'd0, 32'd5, 32'd7, t0);
                issue(0, 5'd0, 32'd1, 32'd2, t2);
            end
            begin
                issue(1, 5'd0, 32'd5, 32'd7, t1);
            end
        join
        chk("contend_req1_after_req0", 32'(t1 - t0), 32'd4);
        chk("contend_req0_after_req1", 32'(t2 - t1), 32'd4);
        wait_rsp(t0);
        chk("contend_last_data", rsp_data, 32'd3);
        @(posedge clk);
        #1;

        // Illegal opcodes bypass the ALU entirely
        en_cnt = 0;
        issue(1, 5'd6, 32'h1234_5678, 32'h1, t0);
        wait_rsp(t1);
        chk("fp_latency", 32'(t1 - t0), 32'd1);
        chk("fp_err", 32'(rsp_err), 32'd1);
        chk("fp_data", rsp_data, 32'd0);
        chk("fp_id", 32'(rsp_id), 32'd1);
        @(posedge clk);
        #1;
        issue(1, 5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
        wait_rsp(t1);
        chk("op20_latency", 32'(t1 - t0), 32'd1);
        chk("op20_err", 32'(rsp_err), 32'd1);
        chk("op20_data", rsp_data, 32'd0);
        chk("illegal_enable_cycles", 32'(en_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure on a multiply while req1 waits
        rsp_ready = 1'b0;
        issue(0, 5'd4, 32'h0001_0003, 32'h0000_0100, t0);
        wait_rsp(t1);
        chk("mul_latency", 32'(t1 - t0), 32'd5);
        chk("mul_data", rsp_data, 32'h0100_0300);
        @(posedge clk);
        #1;
        req1_opcode = 5'd0; req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_data", rsp_data, 32'h0100_0300);
            chk("stall_req1_ready", 32'(req1_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        issue(1, 5'd0, 32'd1, 32'd1, t2);
        chk("stall_release_accept", 32'(t2 - t1), 32'd8);
        wait_rsp(t0);
        chk("after_stall_data", rsp_data, 32'd2);
        @(posedge clk);
        #1;

        // Asynchronous reset in the second EXEC cycle of a multiply
        issue(0, 5'd4, 32'd9, 32'd9, t0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_enable", 32'(alu_enable), 32'd0);
        chk("async_rst_alu_a", alu_a, 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(0, 5'd9, 32'd1, 32'd2, t0);
        wait_rsp(t1);
        chk("post_rst_latency", 32'(t1 - t0), 32'd2);
        chk("post_rst_data", rsp_data, 32'd3);
        chk("post_rst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;

        // Randomised traffic from both requesters with random consumer stalls
        fork
            begin
                fork
                    rand_port(0, 150);
                    rand_port(1, 150);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
